// File: rtl/parser_conf_pkg.sv
// Shared definitions for the staged rule configuration port: field selects,
// commit FSM states and register-address bit positions.
package parser_conf_pkg;

  typedef enum logic [2:0] {
    FIELD_RULE        = 3'd0,
    FIELD_TYPE        = 3'd1,
    FIELD_TYPE_OFFSET = 3'd2,
    FIELD_KEY_OFFSET  = 3'd3,
    FIELD_HEAD_SHIFT  = 3'd4,
    FIELD_META_SHIFT  = 3'd5,
    FIELD_COMMIT      = 3'd6,
    FIELD_STATUS      = 3'd7
  } field_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    COPY  = 2'd2
  } state_e;

  localparam int ADDR_STAGE_LSB  = 12;
  localparam int ADDR_STAGE_W    = 4;
  localparam int ADDR_ACTIVE_BIT = 11;
  localparam int ADDR_FIELD_LSB  = 8;
  localparam int ADDR_FIELD_W    = 3;
  localparam int ADDR_INDEX_LSB  = 0;
  localparam int ADDR_INDEX_W    = 6;
  localparam int DATA_HI_LSB     = 16;
  localparam int KEY_VALID_BIT   = 16;

endpackage

// File: rtl/rule_conf_stage_regs.sv
// One parser stage's shadow and active configuration: write decode into the
// shadow copy, atomic shadow-to-active copy, and the readback mux.
module rule_conf_stage_regs
  import parser_conf_pkg::*;
#(
  parameter int TYPE_NUM          = 4,
  parameter int TYPE_WIDTH        = 16,
  parameter int TYPE_OFFSET_WIDTH = 8,
  parameter int KEY_FIELD_NUM     = 8,
  parameter int KEY_OFFSET_WIDTH  = 6,
  parameter int HEAD_SHIFT_WIDTH  = 6,
  parameter int META_SHIFT_WIDTH  = 6
) (
  input  logic                                               i_clk,
  input  logic                                               i_rst,
  input  logic                                               wr_en,
  input  field_e                                             field,
  input  logic [ADDR_INDEX_W-1:0]                            index,
  input  logic [31:0]                                        wdata,
  input  logic                                               rd_active,
  input  logic                                               copy_en,
  output logic [31:0]                                        rd_data,
  output logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]                type_data,
  output logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]                type_mask,
  output logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]         type_offset,
  output logic [KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH:0]       key_offset,
  output logic [HEAD_SHIFT_WIDTH-1:0]                        head_shift,
  output logic [META_SHIFT_WIDTH-1:0]                        meta_shift
);

  logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]          sh_type_data;
  logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]          sh_type_mask;
  logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]   sh_type_offset;
  logic [KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH:0] sh_key_offset;
  logic [HEAD_SHIFT_WIDTH-1:0]                  sh_head_shift;
  logic [META_SHIFT_WIDTH-1:0]                  sh_meta_shift;

  // Out-of-range indices match no loop iteration, so they fall through untouched.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sh_type_data   <= '0;
      sh_type_mask   <= '0;
      sh_type_offset <= '0;
      sh_key_offset  <= '0;
      sh_head_shift  <= '0;
      sh_meta_shift  <= '0;
      type_data      <= '0;
      type_mask      <= '0;
      type_offset    <= '0;
      key_offset     <= '0;
      head_shift     <= '0;
      meta_shift     <= '0;
    end else begin
      if (wr_en) begin
        case (field)
          FIELD_TYPE: begin
            for (int i = 0; i < TYPE_NUM; i++) begin
              if (index == ADDR_INDEX_W'(i)) begin
                sh_type_data[i] <= wdata[DATA_HI_LSB +: TYPE_WIDTH];
                sh_type_mask[i] <= wdata[0 +: TYPE_WIDTH];
              end
            end
          end
          FIELD_TYPE_OFFSET: begin
            for (int i = 0; i < TYPE_NUM; i++) begin
              if (index == ADDR_INDEX_W'(i)) sh_type_offset[i] <= wdata[0 +: TYPE_OFFSET_WIDTH];
            end
          end
          FIELD_KEY_OFFSET: begin
            for (int i = 0; i < KEY_FIELD_NUM; i++) begin
              if (index == ADDR_INDEX_W'(i))
                sh_key_offset[i] <= {wdata[KEY_VALID_BIT], wdata[0 +: KEY_OFFSET_WIDTH]};
            end
          end
          FIELD_HEAD_SHIFT: if (index == '0) sh_head_shift <= wdata[0 +: HEAD_SHIFT_WIDTH];
          FIELD_META_SHIFT: if (index == '0) sh_meta_shift <= wdata[0 +: META_SHIFT_WIDTH];
          default: ;
        endcase
      end
      if (copy_en) begin
        type_data   <= sh_type_data;
        type_mask   <= sh_type_mask;
        type_offset <= sh_type_offset;
        key_offset  <= sh_key_offset;
        head_shift  <= sh_head_shift;
        meta_shift  <= sh_meta_shift;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (field)
      FIELD_TYPE: begin
        for (int i = 0; i < TYPE_NUM; i++) begin
          if (index == ADDR_INDEX_W'(i)) begin
            rd_data[DATA_HI_LSB +: TYPE_WIDTH] = rd_active ? type_data[i] : sh_type_data[i];
            rd_data[0 +: TYPE_WIDTH]           = rd_active ? type_mask[i] : sh_type_mask[i];
          end
        end
      end
      FIELD_TYPE_OFFSET: begin
        for (int i = 0; i < TYPE_NUM; i++) begin
          if (index == ADDR_INDEX_W'(i))
            rd_data[0 +: TYPE_OFFSET_WIDTH] = rd_active ? type_offset[i] : sh_type_offset[i];
        end
      end
      FIELD_KEY_OFFSET: begin
        for (int i = 0; i < KEY_FIELD_NUM; i++) begin
          if (index == ADDR_INDEX_W'(i)) begin
            rd_data[KEY_VALID_BIT] = rd_active ? key_offset[i][KEY_OFFSET_WIDTH]
                                               : sh_key_offset[i][KEY_OFFSET_WIDTH];
            rd_data[0 +: KEY_OFFSET_WIDTH] = rd_active ? key_offset[i][KEY_OFFSET_WIDTH-1:0]
                                                       : sh_key_offset[i][KEY_OFFSET_WIDTH-1:0];
          end
        end
      end
      FIELD_HEAD_SHIFT:
        if (index == '0) rd_data[0 +: HEAD_SHIFT_WIDTH] = rd_active ? head_shift : sh_head_shift;
      FIELD_META_SHIFT:
        if (index == '0) rd_data[0 +: META_SHIFT_WIDTH] = rd_active ? meta_shift : sh_meta_shift;
      default: ;
    endcase
  end

endmodule

// File: rtl/rule_conf_staged.sv
// Host-facing rule configuration port for STAGE_NUM parser stages: request
// decode, rule-write pulses, readback pipeline and the drain/commit FSM.
module rule_conf_staged
  import parser_conf_pkg::*;
#(
  parameter int STAGE_NUM         = 4,
  parameter int RULE_NUM          = 16,
  parameter int TYPE_NUM          = 4,
  parameter int TYPE_WIDTH        = 16,
  parameter int TYPE_OFFSET_WIDTH = 8,
  parameter int KEY_FIELD_NUM     = 8,
  parameter int KEY_OFFSET_WIDTH  = 6,
  parameter int HEAD_SHIFT_WIDTH  = 6,
  parameter int META_SHIFT_WIDTH  = 6,
  parameter int DRAIN_TIMEOUT     = 255
) (
  input  logic                                                     i_clk,
  input  logic                                                     i_rst,
  input  logic                                                     i_rule_wren,
  input  logic                                                     i_rule_rden,
  input  logic [31:0]                                              i_rule_addr,
  input  logic [31:0]                                              i_rule_wdata,
  output logic                                                     o_rule_ready,
  output logic                                                     o_rule_rvalid,
  output logic [31:0]                                              o_rule_rdata,
  input  logic [STAGE_NUM-1:0]                                     i_stage_idle,
  output logic [STAGE_NUM-1:0][RULE_NUM-1:0]                       o_typeRule_wren,
  output logic                                                     o_typeRule_valid,
  output logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_WIDTH-1:0]       o_typeRule_typeData,
  output logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_WIDTH-1:0]       o_typeRule_typeMask,
  output logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0] o_typeRule_typeOffset,
  output logic [STAGE_NUM-1:0][KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH:0] o_typeRule_keyOffset,
  output logic [STAGE_NUM-1:0][HEAD_SHIFT_WIDTH-1:0]               o_typeRule_headShift,
  output logic [STAGE_NUM-1:0][META_SHIFT_WIDTH-1:0]               o_typeRule_metaShift,
  output logic                                                     o_commit_done,
  output logic                                                     o_err_timeout
);

  localparam int CNT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DRAIN_TIMEOUT);

  state_e                       state, state_next;
  logic [CNT_W-1:0]             drain_cnt;
  logic [STAGE_NUM-1:0]         target, commit_mask, copy_en, stage_wr;
  logic [STAGE_NUM-1:0][31:0]   stage_rd;
  logic [31:0]                  rd_mux;
  logic [ADDR_STAGE_W-1:0]      stage_id;
  logic [ADDR_INDEX_W-1:0]      index;
  field_e                       field;
  logic                         rd_active, stage_ok, wr_acc, rd_acc, commit_req, all_idle;
  logic                         unused_addr;

  assign stage_id    = i_rule_addr[ADDR_STAGE_LSB +: ADDR_STAGE_W];
  assign field       = field_e'(i_rule_addr[ADDR_FIELD_LSB +: ADDR_FIELD_W]);
  assign index       = i_rule_addr[ADDR_INDEX_LSB +: ADDR_INDEX_W];
  assign rd_active   = i_rule_addr[ADDR_ACTIVE_BIT];
  assign unused_addr = ^{i_rule_addr[31:16], i_rule_addr[7:6]};

  assign stage_ok     = 32'(stage_id) < STAGE_NUM;
  assign o_rule_ready = (state == IDLE);
  assign wr_acc       = i_rule_wren && o_rule_ready;
  assign rd_acc       = i_rule_rden && o_rule_ready;
  assign commit_req   = wr_acc && (field == FIELD_COMMIT) &&
                        (i_rule_wdata[1] || (i_rule_wdata[0] && stage_ok));
  // Stages outside the commit target never hold up the drain.
  assign all_idle     = &(i_stage_idle | ~target);

  always_comb begin
    commit_mask = '0;
    if (i_rule_wdata[1]) commit_mask = '1;
    else begin
      for (int s = 0; s < STAGE_NUM; s++)
        if (stage_id == ADDR_STAGE_W'(s)) commit_mask[s] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (commit_req) state_next = DRAIN;
      DRAIN:   if (all_idle || drain_cnt == CNT_MAX) state_next = COPY;
      COPY:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The timeout flag is raised only when the counter, not stage idleness, ends DRAIN.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      target        <= '0;
      drain_cnt     <= '0;
      o_err_timeout <= 1'b0;
      o_commit_done <= 1'b0;
    end else begin
      o_commit_done <= (state == COPY);
      if (commit_req) target <= commit_mask;
      if (state == DRAIN) begin
        if (!all_idle && drain_cnt != CNT_MAX) drain_cnt <= drain_cnt + 1'b1;
        if (!all_idle && drain_cnt == CNT_MAX) o_err_timeout <= 1'b1;
      end else begin
        drain_cnt <= '0;
      end
      if (wr_acc && field == FIELD_STATUS && i_rule_wdata[0]) o_err_timeout <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_typeRule_wren  <= '0;
      o_typeRule_valid <= 1'b0;
    end else begin
      for (int s = 0; s < STAGE_NUM; s++)
        for (int r = 0; r < RULE_NUM; r++)
          o_typeRule_wren[s][r] <= wr_acc && (field == FIELD_RULE) &&
                                   (stage_id == ADDR_STAGE_W'(s)) && (index == ADDR_INDEX_W'(r));
      if (wr_acc && field == FIELD_RULE && stage_ok && 32'(index) < RULE_NUM)
        o_typeRule_valid <= i_rule_wdata[0];
    end
  end

  always_comb begin
    for (int s = 0; s < STAGE_NUM; s++) begin
      stage_wr[s] = wr_acc && (stage_id == ADDR_STAGE_W'(s)) &&
                    (field inside {FIELD_TYPE, FIELD_TYPE_OFFSET, FIELD_KEY_OFFSET,
                                   FIELD_HEAD_SHIFT, FIELD_META_SHIFT});
      copy_en[s]  = (state == COPY) && target[s];
    end
  end

  for (genvar s = 0; s < STAGE_NUM; s++) begin : g_stage
    rule_conf_stage_regs #(
      .TYPE_NUM          (TYPE_NUM),
      .TYPE_WIDTH        (TYPE_WIDTH),
      .TYPE_OFFSET_WIDTH (TYPE_OFFSET_WIDTH),
      .KEY_FIELD_NUM     (KEY_FIELD_NUM),
      .KEY_OFFSET_WIDTH  (KEY_OFFSET_WIDTH),
      .HEAD_SHIFT_WIDTH  (HEAD_SHIFT_WIDTH),
      .META_SHIFT_WIDTH  (META_SHIFT_WIDTH)
    ) u_stage_regs (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .wr_en       (stage_wr[s]),
      .field       (field),
      .index       (index),
      .wdata       (i_rule_wdata),
      .rd_active   (rd_active),
      .copy_en     (copy_en[s]),
      .rd_data     (stage_rd[s]),
      .type_data   (o_typeRule_typeData[s]),
      .type_mask   (o_typeRule_typeMask[s]),
      .type_offset (o_typeRule_typeOffset[s]),
      .key_offset  (o_typeRule_keyOffset[s]),
      .head_shift  (o_typeRule_headShift[s]),
      .meta_shift  (o_typeRule_metaShift[s])
    );
  end

  always_comb begin
    rd_mux = '0;
    if (field == FIELD_STATUS) rd_mux = {29'b0, state, o_err_timeout};
    else begin
      for (int s = 0; s < STAGE_NUM; s++)
        if (stage_id == ADDR_STAGE_W'(s)) rd_mux = stage_rd[s];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rule_rvalid <= 1'b0;
      o_rule_rdata  <= '0;
    end else begin
      o_rule_rvalid <= rd_acc;
      if (rd_acc) o_rule_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_rule_conf_staged.sv
// Randomized, self-checking bench for rule_conf_staged against a register-map
// model keyed by (stage, field, index).
module tb_rule_conf_staged;

  localparam int STAGE_NUM = 4, RULE_NUM = 16, TYPE_NUM = 4, TW = 16, TOW = 8;
  localparam int KFN = 8, KOW = 6, HSW = 6, MSW = 6, DRAIN_TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst, wren, rden, ready, rvalid, valid_o, done, err;
  logic [31:0] addr, wdata, rdata;
  logic [STAGE_NUM-1:0] stage_idle;
  logic [STAGE_NUM-1:0][RULE_NUM-1:0] tr_wren;
  logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TW-1:0] tr_data, tr_mask;
  logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TOW-1:0] tr_off;
  logic [STAGE_NUM-1:0][KFN-1:0][KOW:0] tr_key;
  logic [STAGE_NUM-1:0][HSW-1:0] tr_head;
  logic [STAGE_NUM-1:0][MSW-1:0] tr_meta;

  int total = 0, bad = 0;
  logic [31:0] m_shadow [STAGE_NUM][8][8];
  logic [31:0] m_active [STAGE_NUM][8][8];

  always #5 clk = ~clk;

  rule_conf_staged dut (
    .i_clk(clk), .i_rst(rst), .i_rule_wren(wren), .i_rule_rden(rden),
    .i_rule_addr(addr), .i_rule_wdata(wdata), .o_rule_ready(ready),
    .o_rule_rvalid(rvalid), .o_rule_rdata(rdata), .i_stage_idle(stage_idle),
    .o_typeRule_wren(tr_wren), .o_typeRule_valid(valid_o),
    .o_typeRule_typeData(tr_data), .o_typeRule_typeMask(tr_mask),
    .o_typeRule_typeOffset(tr_off), .o_typeRule_keyOffset(tr_key),
    .o_typeRule_headShift(tr_head), .o_typeRule_metaShift(tr_meta),
    .o_commit_done(done), .o_err_timeout(err)
  );

  function automatic logic [31:0] mk_addr(int stage, bit act, int f, int idx);
    return {16'b0, 4'(stage), act, 3'(f), 2'b0, 6'(idx)};
  endfunction

  function automatic int field_count(int f);
    case (f)
      1, 2:    return TYPE_NUM;
      3:       return KFN;
      4, 5:    return 1;
      default: return 0;
    endcase
  endfunction

  // Bits of a write that a field keeps, in readback positions.
  function automatic logic [31:0] field_mask(int f);
    case (f)
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_00FF;
      3:       return 32'h0001_003F;
      4, 5:    return 32'h0000_003F;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(int stage, bit act, int f, int idx);
    if (stage >= STAGE_NUM || idx >= field_count(f)) return 32'h0;
    return act ? m_active[stage][f][idx] : m_shadow[stage][f][idx];
  endfunction

  task automatic model_write(int stage, int f, int idx, logic [31:0] d);
    if (stage < STAGE_NUM && idx < field_count(f)) m_shadow[stage][f][idx] = d & field_mask(f);
  endtask

  task automatic model_commit(logic [STAGE_NUM-1:0] tgt);
    for (int s = 0; s < STAGE_NUM; s++)
      if (tgt[s]) for (int f = 0; f < 8; f++) for (int i = 0; i < 8; i++)
        m_active[s][f][i] = m_shadow[s][f][i];
  endtask

  task automatic model_reset();
    for (int s = 0; s < STAGE_NUM; s++) for (int f = 0; f < 8; f++) for (int i = 0; i < 8; i++) begin
      m_shadow[s][f][i] = 32'h0;
      m_active[s][f][i] = 32'h0;
    end
  endtask

  task automatic bus_write(logic [31:0] a, logic [31:0] d);
    @(negedge clk);
    wren = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic bus_read(logic [31:0] a, output logic [31:0] d, output logic v);
    @(negedge clk);
    rden = 1'b1; addr = a;
    @(negedge clk);
    rden = 1'b0;
    d = rdata; v = rvalid;
  endtask

  task automatic wait_ready(int limit, output int cycles);
    cycles = 0;
    while (!ready && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
    total++; if (rvalid !== 1'b0 || rdata !== 32'h0) begin bad++; $display("FAIL reset_read got=%b/%h exp=0/0", rvalid, rdata); end
    total++; if (tr_wren !== '0 || valid_o !== 1'b0) begin bad++; $display("FAIL reset_rule got=%h/%b exp=0/0", tr_wren, valid_o); end
    total++; if (tr_data !== '0 || tr_key !== '0 || done !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL reset_active got data=%h key=%h done=%b err=%b exp=0", tr_data, tr_key, done, err); end
    bus_read(mk_addr(0, 0, 7, 0), d, v);
    total++; if (d !== 32'h0 || v !== 1'b1) begin bad++; $display("FAIL reset_status got=%h/%b exp=0/1", d, v); end
  endtask

  task automatic test_shadow_write();
    logic [31:0] d; logic v;
    bus_write(mk_addr(2, 0, 1, 3), 32'hABCD_00FF);
    model_write(2, 1, 3, 32'hABCD_00FF);
    bus_read(mk_addr(2, 0, 1, 3), d, v);
    total++; if (d !== 32'hABCD_00FF || v !== 1'b1) begin bad++; $display("FAIL shadow_read got=%h/%b exp=abcd00ff/1", d, v); end
    bus_read(mk_addr(2, 1, 1, 3), d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL active_before_commit got=%h exp=0", d); end
    total++; if (tr_data[2][3] !== 16'h0) begin bad++; $display("FAIL typedata_before_commit got=%h exp=0", tr_data[2][3]); end
  endtask

  task automatic test_commit_idle();
    logic [31:0] d; logic v;
    stage_idle = 4'b1111;
    bus_write(mk_addr(2, 0, 6, 0), 32'h1);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL commit_drain_ready got=%b exp=0", ready); end
    @(negedge clk);
    total++; if (tr_data[2][3] !== 16'h0 || done !== 1'b0) begin bad++; $display("FAIL commit_n2 got=%h/%b exp=0/0", tr_data[2][3], done); end
    @(negedge clk);
    total++; if (tr_data[2][3] !== 16'hABCD || tr_mask[2][3] !== 16'h00FF) begin
      bad++; $display("FAIL commit_active got=%h/%h exp=abcd/00ff", tr_data[2][3], tr_mask[2][3]); end
    total++; if (done !== 1'b1 || ready !== 1'b1) begin bad++; $display("FAIL commit_done_n3 got=%b/%b exp=1/1", done, ready); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL commit_done_once got=%b exp=0", done); end
    model_commit(4'b0100);
    bus_read(mk_addr(2, 1, 1, 3), d, v);
    total++; if (d !== model_read(2, 1, 1, 3)) begin bad++; $display("FAIL commit_active_read got=%h exp=%h", d, model_read(2, 1, 1, 3)); end
  endtask

  task automatic test_rule_write();
    logic [STAGE_NUM-1:0][RULE_NUM-1:0] exp;
    exp = '0; exp[1][5] = 1'b1;
    bus_write(mk_addr(1, 0, 0, 5), 32'h1);
    total++; if (tr_wren !== exp || valid_o !== 1'b1) begin bad++; $display("FAIL rule_pulse got=%h/%b exp=%h/1", tr_wren, valid_o, exp); end
    @(negedge clk);
    total++; if (tr_wren !== '0 || valid_o !== 1'b1) begin bad++; $display("FAIL rule_pulse_end got=%h/%b exp=0/1", tr_wren, valid_o); end
    bus_write(mk_addr(7, 0, 0, 5), 32'h0);
    total++; if (tr_wren !== '0 || valid_o !== 1'b1) begin bad++; $display("FAIL rule_bad_stage got=%h/%b exp=0/1", tr_wren, valid_o); end
    exp = '0; exp[3][15] = 1'b1;
    bus_write(mk_addr(3, 0, 0, 15), 32'h0);
    total++; if (tr_wren !== exp || valid_o !== 1'b0) begin bad++; $display("FAIL rule_last_index got=%h/%b exp=%h/0", tr_wren, valid_o, exp); end
  endtask

  task automatic test_read_during_write();
    logic [31:0] old_v;
    old_v = model_read(0, 0, 2, 1);
    @(negedge clk);
    wren = 1'b1; rden = 1'b1; addr = mk_addr(0, 0, 2, 1); wdata = 32'h1234_565A;
    @(negedge clk);
    wren = 1'b0; rden = 1'b0;
    model_write(0, 2, 1, 32'h1234_565A);
    total++; if (rdata !== old_v || rvalid !== 1'b1) begin bad++; $display("FAIL read_during_write got=%h exp=%h", rdata, old_v); end
    @(negedge clk);
    rden = 1'b1;
    @(negedge clk);
    rden = 1'b0;
    total++; if (rdata !== 32'h5A) begin bad++; $display("FAIL read_after_write got=%h exp=0000005a", rdata); end
  endtask

  task automatic test_timeout();
    int cyc; logic [31:0] d; logic v;
    stage_idle = 4'b0000;
    bus_write(mk_addr(0, 0, 6, 0), 32'h2);
    wait_ready(1000, cyc);
    model_commit(4'b1111);
    total++; if (cyc !== DRAIN_TIMEOUT + 2) begin bad++; $display("FAIL timeout_busy_cycles got=%0d exp=%0d", cyc, DRAIN_TIMEOUT + 2); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL timeout_err got=%b exp=1", err); end
    bus_read(mk_addr(0, 0, 7, 0), d, v);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL timeout_status got=%h exp=1", d); end
    bus_write(mk_addr(0, 0, 7, 0), 32'h1);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL timeout_clear got=%b exp=0", err); end
    stage_idle = 4'b1111;
  endtask

  task automatic test_drain_drop();
    int cyc; logic [31:0] d; logic v;
    stage_idle = 4'b0000;
    bus_write(mk_addr(0, 0, 6, 0), 32'h1);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL drop_ready got=%b exp=0", ready); end
    bus_write(mk_addr(0, 0, 4, 0), 32'h15);
    stage_idle = 4'b0001;
    wait_ready(50, cyc);
    total++; if (cyc >= 50) begin bad++; $display("FAIL drop_wait got=%0d cycles exp<50", cyc); end
    model_commit(4'b0001);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL drop_err got=%b exp=0", err); end
    bus_read(mk_addr(0, 0, 4, 0), d, v);
    total++; if (d !== model_read(0, 0, 4, 0)) begin bad++; $display("FAIL drop_shadow got=%h exp=%h", d, model_read(0, 0, 4, 0)); end
    stage_idle = 4'b1111;
  endtask

  task automatic test_random();
    int cyc, st, f, idx; bit act; logic [31:0] d, a, e; logic v;
    logic [STAGE_NUM-1:0] tgt;
    stage_idle = 4'b1111;
    for (int round = 0; round < 4; round++) begin
      for (int op = 0; op < 20; op++) begin
        st = $urandom_range(0, 5); f = $urandom_range(1, 5); idx = $urandom_range(0, 9);
        act = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 2) != 2) begin
          d = $urandom;
          bus_write(mk_addr(st, 0, f, idx), d);
          model_write(st, f, idx, d);
        end else begin
          a = mk_addr(st, act, f, idx);
          e = model_read(st, act, f, idx);
          bus_read(a, d, v);
          total++; if (d !== e || v !== 1'b1) begin bad++; $display("FAIL rand_read addr=%h got=%h/%b exp=%h/1", a, d, v, e); end
        end
      end
      st = $urandom_range(0, STAGE_NUM - 1);
      tgt = (round % 2 == 0) ? 4'b1111 : 4'(1 << st);
      bus_write(mk_addr(st, 0, 6, 0), (round % 2 == 0) ? 32'h3 : 32'h1);
      wait_ready(20, cyc);
      total++; if (cyc >= 20) begin bad++; $display("FAIL rand_commit_wait got=%0d cycles exp<20", cyc); end
      model_commit(tgt);
      for (int s = 0; s < STAGE_NUM; s++) begin
        for (int i = 0; i < TYPE_NUM; i++) begin
          total++; if (tr_data[s][i] !== m_active[s][1][i][31:16] || tr_mask[s][i] !== m_active[s][1][i][15:0] ||
                       tr_off[s][i] !== m_active[s][2][i][7:0]) begin
            bad++; $display("FAIL rand_type s=%0d i=%0d got=%h/%h/%h exp=%h/%h", s, i, tr_data[s][i], tr_mask[s][i], tr_off[s][i],
                            m_active[s][1][i], m_active[s][2][i][7:0]); end
        end
        for (int i = 0; i < KFN; i++) begin
          total++; if (tr_key[s][i] !== {m_active[s][3][i][16], m_active[s][3][i][5:0]}) begin
            bad++; $display("FAIL rand_key s=%0d i=%0d got=%h exp=%h", s, i, tr_key[s][i], m_active[s][3][i]); end
        end
        total++; if (tr_head[s] !== m_active[s][4][0][5:0] || tr_meta[s] !== m_active[s][5][0][5:0]) begin
          bad++; $display("FAIL rand_shift s=%0d got=%h/%h exp=%h/%h", s, tr_head[s], tr_meta[s], m_active[s][4][0], m_active[s][5][0]); end
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    int pulses; logic [31:0] d; logic v;
    bus_write(mk_addr(3, 0, 5, 0), 32'h2A);
    stage_idle = 4'b0000;
    bus_write(mk_addr(0, 0, 6, 0), 32'h2);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    total++; if (ready !== 1'b1 || err !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL mid_reset_ctrl got=%b/%b/%b exp=1/0/0", ready, err, done); end
    total++; if (tr_data !== '0 || tr_mask !== '0 || tr_off !== '0 || tr_key !== '0 || tr_head !== '0 || tr_meta !== '0) begin
      bad++; $display("FAIL mid_reset_active got data=%h key=%h exp=0", tr_data, tr_key); end
    total++; if (rvalid !== 1'b0 || rdata !== 32'h0 || valid_o !== 1'b0 || tr_wren !== '0) begin
      bad++; $display("FAIL mid_reset_outs got=%b/%h/%b exp=0/0/0", rvalid, rdata, valid_o); end
    pulses = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL mid_reset_done got=%0d pulses exp=0", pulses); end
    bus_read(mk_addr(3, 0, 5, 0), d, v);
    total++; if (d !== model_read(3, 0, 5, 0)) begin bad++; $display("FAIL mid_reset_shadow got=%h exp=%h", d, model_read(3, 0, 5, 0)); end
    bus_read(mk_addr(0, 0, 7, 0), d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_reset_status got=%h exp=0", d); end
    stage_idle = 4'b1111;
  endtask

  initial begin
    rst = 1'b1; wren = 1'b0; rden = 1'b0; addr = 32'h0; wdata = 32'h0; stage_idle = 4'b1111;
    model_reset();
    test_reset();
    test_shadow_write();
    test_commit_idle();
    test_rule_write();
    test_read_during_write();
    test_timeout();
    test_drain_drop();
    test_random();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rule_conf_staged.md
# rule_conf_staged

Parametrised, multi-stage successor to the parser's 32-bit rule configuration port. It decodes register writes into per-stage shadow configuration and rule-write pulses, and reads back shadow or active values. A commit FSM copies shadow to active atomically, either when the targeted parser stages report idle or when a drain timeout expires. It sits between the host register bus and the STAGE_NUM parser stages.

## Interface
- STAGE_NUM, 4, parser stages configured
- RULE_NUM, 16, rules per stage (≤64)
- TYPE_NUM, 4, type fields per stage (≤16)
- TYPE_WIDTH, 16, type data/mask width (≤16)
- TYPE_OFFSET_WIDTH, 8, type offset width
- KEY_FIELD_NUM, 8, key fields per stage (≤64)
- KEY_OFFSET_WIDTH, 6, key offset width (≤16)
- HEAD_SHIFT_WIDTH, 6 / META_SHIFT_WIDTH, 6, shift widths
- DRAIN_TIMEOUT, 255, max DRAIN cycles before forced commit (≥1)
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_rule_wren  in  1  write request
- i_rule_rden  in  1  read request
- i_rule_addr  in  32  [15:12] stage id, [11] read active(1)/shadow(0), [10:8] field, [5:0] index
- i_rule_wdata  in  32  write data
- o_rule_ready  out  1  write/read accepted this cycle
- o_rule_rvalid  out  1  read data valid
- o_rule_rdata  out  32  read data
- i_stage_idle  in  STAGE_NUM  stage s holds no packet
- o_typeRule_wren  out  [STAGE_NUM][RULE_NUM]  one-cycle rule write pulse
- o_typeRule_valid  out  1  rule valid bit accompanying wren
- o_typeRule_typeData / o_typeRule_typeMask  out  [STAGE_NUM][TYPE_NUM][TYPE_WIDTH]  active
- o_typeRule_typeOffset  out  [STAGE_NUM][TYPE_NUM][TYPE_OFFSET_WIDTH]  active
- o_typeRule_keyOffset  out  [STAGE_NUM][KEY_FIELD_NUM][KEY_OFFSET_WIDTH+1]  active; top bit = key valid
- o_typeRule_headShift / o_typeRule_metaShift  out  [STAGE_NUM][width]  active
- o_commit_done  out  1  one-cycle pulse when copy completes
- o_err_timeout  out  1  sticky: a commit was forced by timeout

## Operation
- Fields (addr[10:8]): 0 rule write, wdata[0] = valid, pulses wren[stage][index]; 1 typeData = wdata[16+:TW], typeMask = wdata[0+:TW]; 2 typeOffset; 3 keyOffset = {wdata[16], wdata[0+:KOW]}; 4 headShift; 5 metaShift; 6 commit control: wdata[0] commits addressed stage, wdata[1] commits all stages (wdata[1] wins); 7 status: write wdata[0]=1 clears o_err_timeout.
- Fields 1–5 write shadow only; active changes only at COPY.
- Stage id ≥ STAGE_NUM or index ≥ field count: write ignored (no pulse, no state change), read returns 0.
- Reads: fields 1–5 return zero-extended value in the same bit positions as writes; addr[11] selects active or shadow. Field 7 reads {29'b0, state[1:0], o_err_timeout}. Fields 0 and 6 read 0.
- FSM: IDLE -(commit accepted)-> DRAIN -(all target stages idle, or count == DRAIN_TIMEOUT)-> COPY -> IDLE. A commit with wdata[1:0] = 0 is a no-op.
- In DRAIN, a counter that starts at 0 increments each cycle the targets are not all idle. On a timeout exit, o_err_timeout is set.
- Reset: all outputs, shadow and active registers 0; state IDLE; counter 0. Reset mid-DRAIN/COPY abandons the commit.

## Timing
- o_rule_ready = (state == IDLE). Requests with ready low are dropped; the host polls field 7.
- Shadow write visible to a read on the next cycle. A read and a write in the same cycle return the pre-write value.
- Read latency 1: o_rule_rvalid/o_rule_rdata registered; rvalid is 0 otherwise and rdata holds its last value.
- wren pulse appears 1 cycle after acceptance, for exactly 1 cycle. o_typeRule_valid is registered with it and holds afterwards.
- Commit accepted at cycle N: DRAIN at N+1. If targets are idle at N+1, state is COPY at N+2 and active outputs plus o_commit_done are updated at N+3.
- Timeout: with targets never idle, DRAIN lasts DRAIN_TIMEOUT+1 cycles.

## Structure
- Package parser_conf_pkg holds the field-select enum, the FSM state enum (IDLE, DRAIN, COPY) and the address bit-position localparams.
- Sub-module rule_conf_stage_regs holds one stage's shadow/active registers, write decode, copy and read mux. It is instantiated STAGE_NUM times. The top level holds the FSM, counter, wren pulse and readback pipeline.

## Test plan
- Write stage 2 field 1 index 3 wdata 0xABCD_00FF → shadow read (addr[11]=0) returns 0xABCD00FF; active read and o_typeRule_typeData[2][3] stay 0.
- Hold i_stage_idle = 4'b1111 and commit stage 2 → o_typeRule_typeData[2][3] = 0xABCD and typeMask = 0x00FF at N+3; o_commit_done pulses once.
- Hold i_stage_idle = 0 and commit all → ready stays low for DRAIN_TIMEOUT+2 cycles; o_err_timeout = 1; field 7 write of 1 clears it.
- Rule write stage 1 index 5 wdata 1 → o_typeRule_wren[1][5] high for exactly one cycle at N+1 and o_typeRule_valid = 1. Stage id 7 write → no pulse.
- Write during DRAIN → dropped; shadow value unchanged after commit finishes.
- Assert i_rst during DRAIN → all outputs 0, state IDLE, o_commit_done never pulses.
